// File: rtl/intr_sched_pkg.sv
// intr_sched_pkg: shared types and constants for the interrupt scheduler.
//   code_t / level_t : cause-code and service-level encodings (0 = none)
//   CODE_*           : cause codes; source n raises code n, code 3 wins
//   state_t          : scheduler FSM states
package intr_sched_pkg;

   localparam int unsigned CODE_W      = 2;
   localparam int unsigned LEVEL_W     = 2;
   localparam int unsigned STACK_DEPTH = 3;

   typedef logic [CODE_W-1:0]  code_t;
   typedef logic [LEVEL_W-1:0] level_t;

   localparam code_t CODE_NONE = 2'd0;
   localparam code_t CODE_IRQ1 = 2'd1;
   localparam code_t CODE_IRQ2 = 2'd2;
   localparam code_t CODE_IRQ3 = 2'd3;

   typedef enum logic [0:0] {
      StIdle,
      StReq
   } state_t;

endpackage

// File: rtl/intr_sched_if.sv
// intr_sched_if: CP0/pipeline handshake bundle for the interrupt scheduler.
//   in_IRQ[3:1] raw lines, in_IE / in_INM CP0 enable and mask, in_ACK break taken,
//   in_eret return pulse; out_BK / out_NIE / out_code break handshake to CP0,
//   out_VEC handler address, out_LEVEL level in service, out_BUSY request pending.
//   slave  : the scheduler side
//   master : the CPU / CP0 side
interface intr_sched_if;
   import intr_sched_pkg::*;

   logic [3:1]  in_IRQ;
   logic        in_IE;
   logic [3:0]  in_INM;
   logic        in_ACK;
   logic        in_eret;
   logic        out_BK;
   logic        out_NIE;
   code_t       out_code;
   logic [31:0] out_VEC;
   level_t      out_LEVEL;
   logic        out_BUSY;

   modport master (
      output in_IRQ, in_IE, in_INM, in_ACK, in_eret,
      input  out_BK, out_NIE, out_code, out_VEC, out_LEVEL, out_BUSY
   );

   modport slave (
      input  in_IRQ, in_IE, in_INM, in_ACK, in_eret,
      output out_BK, out_NIE, out_code, out_VEC, out_LEVEL, out_BUSY
   );

endinterface

// File: rtl/intr_prio_enc.sv
// intr_prio_enc: combinational fixed-priority encoder over three request bits.
//   req[3:1] : active requests, bit n corresponds to cause code n
//   code     : highest active n (CODE_NONE when none)
//   valid    : any request active
module intr_prio_enc
   import intr_sched_pkg::*;
(
   input  logic [3:1] req,
   output code_t      code,
   output logic       valid
);

   always_comb begin
      code = CODE_NONE;
      if (req[3]) begin
         code = CODE_IRQ3;
      end else if (req[2]) begin
         code = CODE_IRQ2;
      end else if (req[1]) begin
         code = CODE_IRQ1;
      end
   end

   assign valid = |req;

endmodule

// File: rtl/intr_sched.sv
// intr_sched: interrupt scheduler sequencing entry into and return from service.
//   in_CLK   : clock, rising edge
//   in_RST_N : synchronous active-low reset
//   bus      : intr_sched_if.slave (IRQ/IE/mask/ACK/eret in; BK/NIE/code/VEC/LEVEL/BUSY out)
//   VEC_BASE / VEC_STRIDE : handler address = VEC_BASE + code * VEC_STRIDE
// Build option: INTR_SCHED_NEST_EN enables preemption by higher-priority sources with a
// 3-entry level stack; without it a new request is taken only at level 0.
module intr_sched
   import intr_sched_pkg::*;
#(
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input logic         in_CLK,
   input logic         in_RST_N,
   intr_sched_if.slave bus
);

   state_t      state_q, state_d;
   logic [3:1]  irq_q;
   logic [3:1]  pend_q, pend_d, pend_clr;
   code_t       req_code_q, req_code_d;
   level_t      level_q, level_d;
   logic [31:0] vec_q, vec_d;

   logic [3:1]  unmasked;
   code_t       cand_code;
   logic        cand_valid;
   logic        eligible;
   logic        unused_inm0;

`ifdef INTR_SCHED_NEST_EN
   level_t [STACK_DEPTH-1:0] stack_q, stack_d;
   logic [1:0]               depth_q, depth_d;
`endif

   assign unused_inm0 = bus.in_INM[0];
   assign unmasked    = pend_q & ~bus.in_INM[3:1];

   intr_prio_enc u_prio_enc (
      .req   (unmasked),
      .code  (cand_code),
      .valid (cand_valid)
   );

`ifdef INTR_SCHED_NEST_EN
   assign eligible = bus.in_IE & cand_valid & (cand_code > level_q);
`else
   assign eligible = bus.in_IE & cand_valid & (level_q == CODE_NONE);
`endif

   always_comb begin
      state_d    = state_q;
      req_code_d = req_code_q;
      level_d    = level_q;
      vec_d      = vec_q;
      pend_clr   = '0;
`ifdef INTR_SCHED_NEST_EN
      stack_d    = stack_q;
      depth_d    = depth_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.in_eret && (level_q != CODE_NONE)) begin
`ifdef INTR_SCHED_NEST_EN
               level_d = stack_q[depth_q - 2'd1];
               depth_d = depth_q - 2'd1;
`else
               level_d = CODE_NONE;
`endif
            end
            // req_code is frozen here; later edges wait until after the ACK
            if (eligible) begin
               state_d    = StReq;
               req_code_d = cand_code;
            end
         end
         StReq: begin
            if (bus.in_ACK) begin
               for (int n = 1; n <= 3; n++) begin
                  if (req_code_q == code_t'(n)) begin
                     pend_clr[n] = 1'b1;
                  end
               end
               level_d = req_code_q;
               vec_d   = VEC_BASE + 32'(req_code_q) * VEC_STRIDE;
`ifdef INTR_SCHED_NEST_EN
               // levels only increase on push, so depth never exceeds the stack size
               stack_d[depth_q] = level_q;
               depth_d          = depth_q + 2'd1;
`endif
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // a fresh edge wins over a same-cycle clear
      pend_d = (pend_q & ~pend_clr) | (bus.in_IRQ & ~irq_q);
   end

   always_ff @(posedge in_CLK) begin
      if (!in_RST_N) begin
         state_q    <= StIdle;
         irq_q      <= '0;
         pend_q     <= '0;
         req_code_q <= CODE_NONE;
         level_q    <= CODE_NONE;
         vec_q      <= '0;
`ifdef INTR_SCHED_NEST_EN
         stack_q    <= '0;
         depth_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         irq_q      <= bus.in_IRQ;
         pend_q     <= pend_d;
         req_code_q <= req_code_d;
         level_q    <= level_d;
         vec_q      <= vec_d;
`ifdef INTR_SCHED_NEST_EN
         stack_q    <= stack_d;
         depth_q    <= depth_d;
`endif
      end
   end

   assign bus.out_BK    = (state_q == StReq);
   assign bus.out_BUSY  = (state_q == StReq);
   assign bus.out_NIE   = (state_q != StReq);
   assign bus.out_code  = (state_q == StReq) ? req_code_q : CODE_NONE;
   assign bus.out_VEC   = vec_q;
   assign bus.out_LEVEL = level_q;

endmodule

// File: tb/tb_intr_sched.sv
// tb_intr_sched: directed bench for intr_sched with a queue-based reference model.
// Works for both builds (INTR_SCHED_NEST_EN defined or not).
module tb_intr_sched;
   import intr_sched_pkg::*;

   localparam logic [31:0] VB = 32'h0000_0100;
   localparam logic [31:0] VS = 32'h0000_0010;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   intr_sched_if sif ();

   intr_sched #(
      .VEC_BASE   (VB),
      .VEC_STRIDE (VS)
   ) dut (
      .in_CLK   (clk),
      .in_RST_N (rst_n),
      .bus      (sif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // reference model state
   logic [3:1]  m_irq_q, m_pend;
   bit          m_busy;
   int          m_req, m_level;
   logic [31:0] m_vec;
   int          m_stk[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: a rising edge makes a source pending; the highest unmasked pending source
   // is requested when enabled and above the current level; ACK enters it, eret returns.
   always @(posedge clk) begin : model
      logic [3:1] rise;
      int         cand;
      bit         elig;
      if (!rst_n) begin
         m_irq_q = '0;
         m_pend  = '0;
         m_busy  = 1'b0;
         m_req   = 0;
         m_level = 0;
         m_vec   = '0;
         m_stk.delete();
         chk_en  = 1'b1;
      end else begin
         rise = sif.in_IRQ & ~m_irq_q;
         cand = 0;
         for (int n = 1; n <= 3; n++) begin
            if (m_pend[n] && !sif.in_INM[n]) cand = n;
         end
`ifdef INTR_SCHED_NEST_EN
         elig = sif.in_IE && (cand > m_level);
`else
         elig = sif.in_IE && (cand != 0) && (m_level == 0);
`endif
         if (m_busy) begin
            if (sif.in_ACK) begin
               m_pend[m_req] = 1'b0;
`ifdef INTR_SCHED_NEST_EN
               m_stk.push_back(m_level);
`endif
               m_level = m_req;
               m_vec   = VB + VS * m_req;
               m_busy  = 1'b0;
            end
         end else begin
            if (elig) begin
               m_busy = 1'b1;
               m_req  = cand;
            end
            if (sif.in_eret && m_level != 0) begin
`ifdef INTR_SCHED_NEST_EN
               m_level = m_stk.pop_back();
`else
               m_level = 0;
`endif
            end
         end
         m_pend  = m_pend | rise;
         m_irq_q = sif.in_IRQ;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_BK",    32'(sif.out_BK),    32'(m_busy));
         chk("cyc_BUSY",  32'(sif.out_BUSY),  32'(m_busy));
         chk("cyc_NIE",   32'(sif.out_NIE),   32'(!m_busy));
         chk("cyc_code",  32'(sif.out_code),  m_busy ? 32'(m_req) : 32'd0);
         chk("cyc_LEVEL", 32'(sif.out_LEVEL), 32'(m_level));
         chk("cyc_VEC",   sif.out_VEC,        m_vec);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      sif.in_IRQ  = '0;
      sif.in_IE   = 1'b1;
      sif.in_INM  = '0;
      sif.in_ACK  = 1'b0;
      sif.in_eret = 1'b0;
      rst_n       = 1'b0;
      step(3);
      chk("rst_BK", 32'(sif.out_BK), 32'd0);
      chk("rst_NIE", 32'(sif.out_NIE), 32'd1);
      chk("rst_VEC", sif.out_VEC, 32'd0);
      chk("rst_LEVEL", 32'(sif.out_LEVEL), 32'd0);
      rst_n = 1'b1;
      step(2);

      // single IRQ
      sif.in_IRQ = 3'b001; step(1); sif.in_IRQ = '0;
      chk("single_t1_BK", 32'(sif.out_BK), 32'd0);
      step(1);
      chk("single_t2_BK", 32'(sif.out_BK), 32'd1);
      chk("single_t2_code", 32'(sif.out_code), 32'd1);
      chk("single_t2_NIE", 32'(sif.out_NIE), 32'd0);
      step(2); sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("single_ack_BK", 32'(sif.out_BK), 32'd0);
      chk("single_ack_LEVEL", 32'(sif.out_LEVEL), 32'd1);
      chk("single_ack_VEC", sif.out_VEC, 32'h110);
      chk("single_ack_NIE", 32'(sif.out_NIE), 32'd1);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("single_eret_LEVEL", 32'(sif.out_LEVEL), 32'd0);
      step(1);

      // ACK without REQ, eret at level 0
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("stray_ack_LEVEL", 32'(sif.out_LEVEL), 32'd0);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("eret_l0_LEVEL", 32'(sif.out_LEVEL), 32'd0);

      // masking
      sif.in_INM = 4'b0100;
      sif.in_IRQ = 3'b010; step(1); sif.in_IRQ = '0;
      step(3);
      chk("mask_hold_BK", 32'(sif.out_BK), 32'd0);
      sif.in_INM = 4'b0000; step(1);
      chk("mask_rel_BK", 32'(sif.out_BK), 32'd1);
      chk("mask_rel_code", 32'(sif.out_code), 32'd2);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("mask_VEC", sif.out_VEC, 32'h120);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(1);

      // IE disabled
      sif.in_IE = 1'b0;
      sif.in_IRQ = 3'b100; step(1); sif.in_IRQ = '0;
      step(3);
      chk("ie_off_BK", 32'(sif.out_BK), 32'd0);
      sif.in_IE = 1'b1; step(1);
      chk("ie_on_code", 32'(sif.out_code), 32'd3);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("ie_VEC", sif.out_VEC, 32'h130);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(1);

      // simultaneous sources
      sif.in_IRQ = 3'b101; step(1); sif.in_IRQ = '0;
      step(1);
      chk("simul_first_code", 32'(sif.out_code), 32'd3);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("simul_LEVEL3", 32'(sif.out_LEVEL), 32'd3);
      step(2);
      chk("simul_wait_BK", 32'(sif.out_BK), 32'd0);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("simul_eret_LEVEL", 32'(sif.out_LEVEL), 32'd0);
      step(1);
      chk("simul_second_code", 32'(sif.out_code), 32'd1);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(1);

      // nesting
      sif.in_IRQ = 3'b001; step(1); sif.in_IRQ = '0;
      step(1);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("nest_LEVEL1", 32'(sif.out_LEVEL), 32'd1);
      sif.in_IRQ = 3'b010; step(1); sif.in_IRQ = '0;
      step(1);
`ifdef INTR_SCHED_NEST_EN
      chk("nest_pre_BK", 32'(sif.out_BK), 32'd1);
      chk("nest_pre_code", 32'(sif.out_code), 32'd2);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("nest_LEVEL2", 32'(sif.out_LEVEL), 32'd2);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("nest_pop1", 32'(sif.out_LEVEL), 32'd1);
      step(1);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("nest_pop0", 32'(sif.out_LEVEL), 32'd0);
`else
      chk("nonest_BK", 32'(sif.out_BK), 32'd0);
      step(2);
      chk("nonest_wait_BK", 32'(sif.out_BK), 32'd0);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("nonest_eret", 32'(sif.out_LEVEL), 32'd0);
      step(1);
      chk("nonest_code", 32'(sif.out_code), 32'd2);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      chk("nonest_LEVEL2", 32'(sif.out_LEVEL), 32'd2);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      chk("nonest_LEVEL0", 32'(sif.out_LEVEL), 32'd0);
`endif
      step(1);

      // level-held line does not re-trigger
      sif.in_IRQ = 3'b001; step(2);
      chk("held_code", 32'(sif.out_code), 32'd1);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      step(2);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(2);
      chk("held_no_retrig", 32'(sif.out_BK), 32'd0);
      sif.in_IRQ = '0; step(1);

      // new edge on the same cycle as the clear keeps the source pending
      sif.in_IRQ = 3'b001; step(1); sif.in_IRQ = '0;
      step(1);
      sif.in_ACK = 1'b1; sif.in_IRQ = 3'b001; step(1);
      sif.in_ACK = 1'b0; sif.in_IRQ = '0;
      chk("setclr_BK", 32'(sif.out_BK), 32'd0);
      chk("setclr_LEVEL", 32'(sif.out_LEVEL), 32'd1);
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(1);
      chk("setclr_rereq", 32'(sif.out_code), 32'd1);
      sif.in_ACK = 1'b1; step(1); sif.in_ACK = 1'b0;
      sif.in_eret = 1'b1; step(1); sif.in_eret = 1'b0;
      step(1);

      // reset mid-REQ
      sif.in_IRQ = 3'b100; step(1); sif.in_IRQ = '0;
      step(1);
      chk("rreq_BK", 32'(sif.out_BK), 32'd1);
      rst_n = 1'b0; step(1); rst_n = 1'b1;
      chk("rreq_BK0", 32'(sif.out_BK), 32'd0);
      chk("rreq_code", 32'(sif.out_code), 32'd0);
      chk("rreq_NIE", 32'(sif.out_NIE), 32'd1);
      chk("rreq_VEC", sif.out_VEC, 32'd0);
      chk("rreq_LEVEL", 32'(sif.out_LEVEL), 32'd0);
      chk("rreq_BUSY", 32'(sif.out_BUSY), 32'd0);
      step(3);
      chk("rreq_lost", 32'(sif.out_BK), 32'd0);

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
